// File: rtl/pipe_latch_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_latch_ctrl
//
// Purpose:
//   Control end of the pipeline-latch enable/clear interface. Turns the
//   load-use hazard, the taken-branch flush and the multdiv start/ready
//   handshake into per-cycle enable/clear controls for the PC and the
//   F/D, D/X, X/M and M/W latches.
//
//   It also owns:
//     - the multdiv wait FSM, which has a timeout watchdog, and
//     - a saturating count of stalled cycles, kept for performance debug.
//
// Parameters:
//   MD_TIMEOUT  most cycles spent in MD_WAIT, release cycle included
//   CNT_W       width of the timeout counter (2**CNT_W > MD_TIMEOUT)
//   STAT_W      width of the stall-cycle statistic counter
//
// Ports:
//   clk, reset_n        clock; asynchronous active-low reset
//   hz_load_use         D-stage instruction depends on a load in X
//   br_taken            X-stage branch/jump resolved taken
//   md_req              X-stage instruction is mult/div (level)
//   md_rdy              multdiv result-ready pulse
//   pc_en               PC register enable
//   fd_en/fd_clr        F/D latch enable / synchronous clear
//   dx_en/dx_clr        D/X latch enable / synchronous clear
//   xm_en/xm_clr        X/M latch enable / synchronous clear
//   mw_en               M/W latch enable (always 1)
//   md_start            one-cycle start pulse to the multdiv unit
//   md_busy             high while waiting on the multdiv unit
//   md_timeout          sticky, registered watchdog error flag
//   stall_cnt           saturating count of cycles with pc_en=0 (registered)
//   dbg_state_o         current FSM state (0 = RUN, 1 = MD_WAIT)
//
// Handshake:
//   md_start is asserted for exactly one cycle, on the RUN->MD_WAIT
//   transition. The unit answers with a single-cycle md_rdy pulse. While
//   waiting, any md_rdy releases the wait.
//
//   If md_rdy has not arrived after MD_TIMEOUT cycles, the wait is released
//   anyway and md_timeout is latched.
//
//   md_rdy seen in RUN carries no meaning and is dropped.
// -----------------------------------------------------------------------------
module pipe_latch_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hz_load_use,
    input  logic              br_taken,
    input  logic              md_req,
    input  logic              md_rdy,
    output logic              pc_en,
    output logic              fd_en,
    output logic              fd_clr,
    output logic              dx_en,
    output logic              dx_clr,
    output logic              xm_en,
    output logic              xm_clr,
    output logic              mw_en,
    output logic              md_start,
    output logic              md_busy,
    output logic              md_timeout,
    output logic [STAT_W-1:0] stall_cnt,
    output logic              dbg_state_o
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                md_timeout_q, md_timeout_d;
    logic [STAT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic                release_w;

    // Wait ends on the ready pulse, or on the last allowed cycle of MD_WAIT.
    assign release_w = md_rdy || (tmo_cnt_q == TMO_LAST);

    // ------------------------------------------------------------------
    // Next-state and combinational control outputs
    // ------------------------------------------------------------------
    always_comb begin
        pc_en        = 1'b1;
        fd_en        = 1'b1;
        fd_clr       = 1'b0;
        dx_en        = 1'b1;
        dx_clr       = 1'b0;
        xm_en        = 1'b1;
        xm_clr       = 1'b0;
        mw_en        = 1'b1;
        md_start     = 1'b0;
        md_busy      = 1'b0;
        state_d      = state_q;
        tmo_cnt_d    = tmo_cnt_q;
        md_timeout_d = md_timeout_q;

        // While reset is held, the latches see plain RUN/no-event controls,
        // whatever the hazard inputs are doing.
        if (reset_n) begin
            unique case (state_q)
                ST_RUN: begin
                    if (md_req) begin
                        // Freeze F/D/X and push a bubble into M while the
                        // multdiv unit computes.
                        md_start  = 1'b1;
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        dx_en     = 1'b0;
                        xm_clr    = 1'b1;
                        state_d   = ST_MD_WAIT;
                        tmo_cnt_d = '0;
                    end else if (br_taken) begin
                        // Squash the two younger instructions.
                        fd_clr = 1'b1;
                        dx_clr = 1'b1;
                    end else if (hz_load_use) begin
                        // Hold F and D for one cycle and insert one bubble into X.
                        pc_en  = 1'b0;
                        fd_en  = 1'b0;
                        dx_clr = 1'b1;
                    end
                end

                ST_MD_WAIT: begin
                    md_busy = 1'b1;
                    if (release_w) begin
                        // Default outputs let the X instruction advance.
                        state_d   = ST_RUN;
                        tmo_cnt_d = '0;
                        if (!md_rdy) begin
                            md_timeout_d = 1'b1;
                        end
                    end else begin
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        dx_en     = 1'b0;
                        xm_clr    = 1'b1;
                        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Stall statistic saturates instead of wrapping so long runs stay readable.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != STAT_MAX)) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            tmo_cnt_q    <= '0;
            md_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            md_timeout_q <= md_timeout_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign md_timeout  = md_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_latch_ctrl.sv
module tb_pipe_latch_ctrl;

    localparam int MD_TIMEOUT = 8;
    localparam int CNT_W      = 4;
    localparam int STAT_W     = 7;
    localparam int STAT_MAX   = (1 << STAT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              hz_load_use;
    logic              br_taken;
    logic              md_req;
    logic              md_rdy;
    logic              pc_en;
    logic              fd_en;
    logic              fd_clr;
    logic              dx_en;
    logic              dx_clr;
    logic              xm_en;
    logic              xm_clr;
    logic              mw_en;
    logic              md_start;
    logic              md_busy;
    logic              md_timeout;
    logic [STAT_W-1:0] stall_cnt;
    logic              dbg_state_o;

    pipe_latch_ctrl #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .CNT_W      (CNT_W),
        .STAT_W     (STAT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hz_load_use (hz_load_use),
        .br_taken    (br_taken),
        .md_req      (md_req),
        .md_rdy      (md_rdy),
        .pc_en       (pc_en),
        .fd_en       (fd_en),
        .fd_clr      (fd_clr),
        .dx_en       (dx_en),
        .dx_clr      (dx_clr),
        .xm_en       (xm_en),
        .xm_clr      (xm_clr),
        .mw_en       (mw_en),
        .md_start    (md_start),
        .md_busy     (md_busy),
        .md_timeout  (md_timeout),
        .stall_cnt   (stall_cnt),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    bit m_wait;     // waiting on multdiv
    int m_waitcyc;  // cycles of the wait already completed
    bit m_tmo;      // sticky timeout flag
    int m_stall;    // stalled cycles seen (saturating)

    // Bit order: {pc,fd_en,fd_clr,dx_en,dx_clr,xm_en,xm_clr,mw_en,start,busy}
    localparam logic [9:0] CTRL_DEFAULT = 10'b11_0_1_0_1_0_1_0_0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] dut_ctrl();
        return {pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_en, xm_clr, mw_en, md_start, md_busy};
    endfunction

    function automatic void model_reset();
        m_wait    = 1'b0;
        m_waitcyc = 0;
        m_tmo     = 1'b0;
        m_stall   = 0;
    endfunction

    // Entered at posedge+2. Drives one cycle, checks at mid-cycle, advances the model.
    task automatic cycle(input bit hz, input bit br, input bit req, input bit rdy);
        bit e_pc, e_fd, e_fclr, e_dx, e_dclr, e_xclr, e_start, e_busy, rel;
        hz_load_use = hz;
        br_taken    = br;
        md_req      = req;
        md_rdy      = rdy;
        #3;
        e_pc = 1; e_fd = 1; e_fclr = 0; e_dx = 1; e_dclr = 0; e_xclr = 0;
        e_start = 0; e_busy = 0; rel = 0;
        if (!m_wait) begin
            if (req) begin
                e_start = 1; e_pc = 0; e_fd = 0; e_dx = 0; e_xclr = 1;
            end else if (br) begin
                e_fclr = 1; e_dclr = 1;
            end else if (hz) begin
                e_pc = 0; e_fd = 0; e_dclr = 1;
            end
        end else begin
            e_busy = 1;
            rel = rdy || (m_waitcyc == MD_TIMEOUT - 1);
            if (!rel) begin
                e_pc = 0; e_fd = 0; e_dx = 0; e_xclr = 1;
            end
        end
        check("ctrl", 32'(dut_ctrl()),
              32'({e_pc, e_fd, e_fclr, e_dx, e_dclr, 1'b1, e_xclr, 1'b1, e_start, e_busy}));
        check("md_timeout", 32'(md_timeout), 32'(m_tmo));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("state", 32'(dbg_state_o), 32'(m_wait));
        // advance model to the next clock edge
        if (!e_pc && m_stall < STAT_MAX) m_stall++;
        if (!m_wait) begin
            if (req) begin
                m_wait    = 1'b1;
                m_waitcyc = 0;
            end
        end else if (rel) begin
            m_wait = 1'b0;
            if (!rdy) m_tmo = 1'b1;
        end else begin
            m_waitcyc++;
        end
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset asserted mid-cycle with busy inputs; outputs must be RUN defaults.
    task automatic do_reset(input int n);
        reset_n     = 1'b0;
        md_req      = 1'b1;
        br_taken    = 1'b1;
        hz_load_use = 1'b1;
        md_rdy      = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            #3;
            check("rst_ctrl", 32'(dut_ctrl()), 32'(CTRL_DEFAULT));
            check("rst_tmo", 32'(md_timeout), 32'd0);
            check("rst_stall", 32'(stall_cnt), 32'd0);
            @(posedge clk);
            #2;
        end
        md_req      = 1'b0;
        br_taken    = 1'b0;
        hz_load_use = 1'b0;
        reset_n     = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0;
        reset_n     = 1'b0;
        hz_load_use = 1'b0;
        br_taken    = 1'b0;
        md_req      = 1'b0;
        md_rdy      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        do_reset(2);

        // idle after reset
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);

        // single branch flush, then single load-use bubble
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        check("br_no_stall", 32'(stall_cnt), 32'd0);
        cycle(1, 0, 0, 0);
        check("hz_stall_one", 32'(stall_cnt), 32'd1);
        cycle(0, 0, 0, 0);

        // multdiv released by md_rdy at t+5
        s0 = int'(stall_cnt);
        cycle(0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 1);
        check("md_rdy_stall5", 32'(int'(stall_cnt) - s0), 32'd5);
        check("md_rdy_no_tmo", 32'(md_timeout), 32'd0);
        cycle(0, 0, 0, 0);

        // multdiv released by timeout
        do_reset(1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        for (int i = 1; i <= MD_TIMEOUT; i++) cycle(0, 0, 1, 0);
        check("tmo_set", 32'(md_timeout), 32'd1);
        check("tmo_stall", 32'(stall_cnt), 32'(MD_TIMEOUT));
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        check("tmo_sticky", 32'(md_timeout), 32'd1);

        // md_rdy on the same cycle as the timeout: rdy wins
        do_reset(1);
        cycle(0, 0, 1, 0);
        for (int i = 1; i < MD_TIMEOUT; i++) cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 1);
        check("rdy_at_tmo", 32'(md_timeout), 32'd0);
        cycle(0, 0, 0, 0);

        // reset in the middle of a wait
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        do_reset(2);
        cycle(0, 0, 0, 0);
        check("mid_rst_busy", 32'(md_busy), 32'd0);
        cycle(0, 0, 0, 0);

        // all three events together: multdiv path wins
        cycle(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 0);

        // saturation of stall statistic
        do_reset(1);
        for (int i = 0; i < STAT_MAX + 12; i++) cycle(1, 0, 0, 0);
        check("stall_sat", 32'(stall_cnt), 32'(STAT_MAX));

        // randomized traffic
        do_reset(1);
        for (int i = 0; i < 2000; i++) begin
            bit r_hz, r_br, r_req, r_rdy;
            if ($urandom_range(0, 399) == 0) begin
                do_reset($urandom_range(1, 2));
            end
            r_hz  = ($urandom_range(0, 3) == 0);
            r_br  = ($urandom_range(0, 4) == 0);
            r_req = m_wait ? 1'b1 : ($urandom_range(0, 5) == 0);
            r_rdy = ($urandom_range(0, 7) == 0);
            cycle(r_hz, r_br, r_req, r_rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_latch_ctrl.md
Name: pipe_latch_ctrl

Overview:
- Control end of the pipeline-latch enable/clear interface. Each pipeline register (F/D, D/X, X/M, M/W) is a bank of synchronous-clear, enabled flip-flops; this block drives their `en` and `clr` pins, plus the PC enable.
- Converts hazard and branch events from decode/execute, and the multdiv start/ready handshake, into per-cycle stall and flush controls.
- Owns the multdiv wait FSM with a timeout watchdog, and a saturating stall-cycle counter for performance debug.

Parameters:
- MD_TIMEOUT, 40, maximum number of cycles spent in MD_WAIT before a forced release.
- CNT_W, 6, width of the timeout counter; must satisfy 2^CNT_W > MD_TIMEOUT.
- STAT_W, 16, width of the stall-cycle statistic counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- hz_load_use  input  1  D-stage instruction depends on a load currently in X.
- br_taken  input  1  X-stage branch or jump resolved taken.
- md_req  input  1  X-stage instruction is mult or div (level).
- md_rdy  input  1  multdiv result-ready pulse.
- pc_en  output  1  PC register enable.
- fd_en, fd_clr  output  1 each  F/D latch enable and clear.
- dx_en, dx_clr  output  1 each  D/X latch enable and clear.
- xm_en, xm_clr  output  1 each  X/M latch enable and clear.
- mw_en  output  1  M/W latch enable; tied to 1.
- md_start  output  1  one-cycle start pulse to the multdiv unit.
- md_busy  output  1  high while the FSM is in MD_WAIT.
- md_timeout  output  1  sticky error flag, registered.
- stall_cnt  output  STAT_W  saturating count of cycles with pc_en=0, registered.

Behaviour:
- Reset (async, reset_n=0):
  - state=RUN, tmo_cnt=0, md_timeout=0, stall_cnt=0.
  - While reset is held, combinational outputs take their RUN/no-event values: all en=1, all clr=0, md_start=0, md_busy=0.
- Control outputs (en, clr, md_start, md_busy) are combinational from state and inputs, so they respond in the same cycle as the input.
- Defaults (RUN, no event): pc_en=fd_en=dx_en=xm_en=mw_en=1; every clr=0.
- RUN priority, highest first: md_req > br_taken > hz_load_use.
  - md_req:
    - md_start=1.
    - pc_en=fd_en=dx_en=0; xm_en=1, xm_clr=1 (bubble into M).
    - Next state MD_WAIT, tmo_cnt<=0.
  - br_taken:
    - fd_clr=1, dx_clr=1; all en=1 (flushes the two younger instructions).
    - State stays RUN.
  - hz_load_use:
    - pc_en=0, fd_en=0; dx_en=1, dx_clr=1 (one bubble).
    - State stays RUN.
  - md_rdy in RUN is ignored.
- MD_WAIT:
  - md_busy=1.
  - hz_load_use, br_taken and md_req are ignored.
  - Non-release cycle:
    - pc_en=fd_en=dx_en=0; xm_en=1, xm_clr=1.
    - tmo_cnt<=tmo_cnt+1.
  - Release condition: md_rdy=1, or tmo_cnt==MD_TIMEOUT-1.
  - Release cycle:
    - Default RUN outputs (all en=1, all clr=0), so the X instruction advances.
    - Next state RUN.
  - If release is by timeout with md_rdy=0, md_timeout<=1. md_timeout stays high until reset.
  - md_rdy and timeout in the same cycle: md_rdy wins; md_timeout is not set.
- Timing:
  - The stall begins in the md_req cycle and ends the cycle before release.
  - MD_WAIT lasts at most MD_TIMEOUT cycles, release cycle included.
- stall_cnt:
  - Increments every cycle in which pc_en=0.
  - Saturates at 2^STAT_W-1; does not wrap.
- md_start pulses only on a RUN→MD_WAIT transition, never twice for one request.
- Reset asserted mid-MD_WAIT: immediate return to RUN; counters and flags cleared; no md_start is issued on reset release.

Test Plan:
- Reset release with all inputs 0 → pc_en/fd_en/dx_en/xm_en/mw_en=1, all clr=0, md_busy=0, stall_cnt=0 for 10 cycles.
- br_taken=1 for one cycle → fd_clr=dx_clr=1 in that cycle only; en stay 1; stall_cnt unchanged.
- hz_load_use=1 for one cycle → pc_en=fd_en=0, dx_clr=1 that cycle; stall_cnt=1 on the next cycle.
- md_req rises at cycle t (held), md_rdy pulses at t+5 → md_start=1 only at t; stall at t..t+4; md_busy at t+1..t+5; all en=1 at t+5; stall_cnt=5; md_timeout=0.
- MD_TIMEOUT=4, md_req at t, no md_rdy → release at t+4; md_timeout=1 from t+5 onward; stall_cnt=4. Repeat with md_rdy at exactly t+4 → md_timeout stays 0.
- md_req at t, reset_n low at t+2 for 2 cycles → immediate RUN outputs; md_busy=0, stall_cnt=0, md_timeout=0 after release; simultaneous md_req+br_taken+hz_load_use in RUN → md path taken (md_start=1, fd_clr=0).
